// File: rtl/inst_encoder.sv
// RV32I instruction packer: fields + immediate in, one registered 32-bit word out with running address.
// Optional IMM_RANGE_CHECK_EN adds immediate range checks to out_err.
module inst_encoder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  addr_load,
  input  logic [ADDR_WIDTH-1:0] addr_base,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_fmt,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [DATA_WIDTH-1:0] in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_err,
  output logic [15:0]           enc_count
);

  localparam logic [DATA_WIDTH-1:0] NOP = 32'h0000_0013;

  // Handshake: a request transfers when in_valid & in_ready, a word leaves when
  // out_valid & out_ready; in_ready frees the stage in the same cycle it drains.
  logic                  accept;
  logic                  out_fire;
  logic                  held;
  logic [DATA_WIDTH-1:0] enc;
  logic                  fmt_bad;
  logic                  range_bad;
  logic                  pend;
  logic [ADDR_WIDTH-1:0] pend_base;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign held     = out_valid & ~out_ready;

  always_comb begin
    enc     = NOP;
    fmt_bad = 1'b0;
    case (in_fmt)
      3'd0: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      3'd1: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      3'd2: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      3'd3: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], in_opcode};
      3'd4: enc = {in_imm[31:12], in_rd, in_opcode};
      3'd5: enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      default: fmt_bad = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // A value fits in N signed bits when bits [31:N-1] are all copies of the sign.
  always_comb begin
    range_bad = 1'b0;
    case (in_fmt)
      3'd1, 3'd2: range_bad = ~((&in_imm[31:11]) | ~(|in_imm[31:11]));
      3'd3:       range_bad = ~((&in_imm[31:12]) | ~(|in_imm[31:12])) | in_imm[0];
      3'd4:       range_bad = |in_imm[11:0];
      3'd5:       range_bad = ~((&in_imm[31:20]) | ~(|in_imm[31:20])) | in_imm[0];
      default:    range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_err   <= 1'b0;
      out_addr  <= RESET_ADDR;
      enc_count <= '0;
      pend      <= 1'b0;
      pend_base <= '0;
    end else begin
      if (out_fire) enc_count <= enc_count + 16'd1;
      if (accept) begin
        out_valid <= 1'b1;
        out_inst  <= enc;
        out_err   <= fmt_bad | range_bad;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      // A held word keeps its address; a base loaded meanwhile waits for the drain.
      if (addr_load && held) begin
        pend      <= 1'b1;
        pend_base <= addr_base;
      end else if (addr_load) begin
        out_addr <= addr_base;
        pend     <= 1'b0;
      end else if (out_fire) begin
        out_addr <= pend ? pend_base : out_addr + ADDR_WIDTH'(4);
        pend     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vectors plus a randomized run
// against a queue-based reference model.
module tb_inst_encoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        addr_load;
  logic [31:0] addr_base;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic [15:0] enc_count;

  int checks = 0;
  int errors = 0;

`ifdef IMM_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  logic [64:0] exp_q[$];  // {err, addr, inst}

  inst_encoder dut (
    .clk(clk), .rst(rst), .addr_load(addr_load), .addr_base(addr_base),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
    req_t r;
    r.fmt = fmt; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.f3 = f3; r.f7 = f7; r.imm = imm;
    return r;
  endfunction

  // Reference encoding built by shifting and masking each field into place.
  function automatic logic [31:0] ref_enc(input req_t r);
    logic [31:0] imm, op, rd, rs1, rs2, f3, f7;
    imm = r.imm; op = 32'(r.op); rd = 32'(r.rd); rs1 = 32'(r.rs1);
    rs2 = 32'(r.rs2); f3 = 32'(r.f3); f7 = 32'(r.f7);
    case (r.fmt)
      3'd0: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      3'd1: return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      3'd2: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | ((imm & 32'h1F) << 7) | op;
      3'd3: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                   | (((imm >> 11) & 32'h1) << 7) | op;
      3'd4: return (imm & 32'hFFFF_F000) | (rd << 7) | op;
      3'd5: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                   | (rd << 7) | op;
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic logic ref_err(input req_t r);
    int  si;
    logic rng;
    si  = $signed(r.imm);
    rng = 1'b0;
    case (r.fmt)
      3'd1, 3'd2: rng = (si < -2048) || (si > 2047);
      3'd3:       rng = (si < -4096) || (si > 4095) || (r.imm % 2 != 0);
      3'd4:       rng = (r.imm % 4096) != 0;
      3'd5:       rng = (si < -1048576) || (si > 1048575) || (r.imm % 2 != 0);
      default:    rng = 1'b0;
    endcase
    return (r.fmt > 3'd5) || (RC && rng);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input req_t r);
    in_fmt = r.fmt; in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
    in_funct3 = r.f3; in_funct7 = r.f7; in_imm = r.imm; in_valid = 1'b1;
  endtask

  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0; addr_load = 1'b0; addr_base = '0; out_ready = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    in_valid = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  req_t addi, sw, beq, lui, jal;

  task automatic test_reset;
    do_reset;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", out_inst); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", out_err); end
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", out_addr); end
    checks++; if (enc_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %0d want 0", enc_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed;
    req_t        v[5];
    logic [31:0] e[5];
    v[0] = addi; v[1] = sw; v[2] = beq; v[3] = lui; v[4] = jal;
    e[0] = 32'h0050_0093; e[1] = 32'h0020_A423; e[2] = 32'hFE00_0EE3;
    e[3] = 32'h1234_52B7; e[4] = 32'h0000_006F;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      drive(v[i]);
      tick;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (out_inst !== e[i]) begin errors++; $display("FAIL dir_inst[%0d]: got %h want %h", i, out_inst, e[i]); end
      checks++; if (out_addr !== 32'(4 * i)) begin errors++; $display("FAIL dir_addr[%0d]: got %h want %h", i, out_addr, 4 * i); end
      checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL dir_err[%0d]: got %b want 0", i, out_err); end
    end
    in_valid = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_drain: got %b want 0", out_valid); end
    checks++; if (enc_count !== 16'd5) begin errors++; $display("FAIL dir_count: got %0d want 5", enc_count); end
  endtask

  task automatic test_backpressure;
    do_reset;
    out_ready = 1'b0;
    drive(addi);
    tick;
    drive(sw);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (out_inst !== 32'h0050_0093) begin errors++; $display("FAIL bp_inst[%0d]: got %h want 00500093", i, out_inst); end
      checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL bp_addr[%0d]: got %h want 0", i, out_addr); end
      tick;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick;
    checks++; if (out_inst !== 32'h0020_A423) begin errors++; $display("FAIL bp_second_inst: got %h want 0020a423", out_inst); end
    checks++; if (out_addr !== 32'h4) begin errors++; $display("FAIL bp_second_addr: got %h want 4", out_addr); end
    checks++; if (enc_count !== 16'd1) begin errors++; $display("FAIL bp_count1: got %0d want 1", enc_count); end
    in_valid = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    checks++; if (enc_count !== 16'd2) begin errors++; $display("FAIL bp_count2: got %0d want 2", enc_count); end
  endtask

  task automatic test_illegal;
    do_reset;
    drive(mk(7, 7'h33, 3, 4, 5, 1, 7'h20, 32'hDEAD));
    tick;
    checks++; if (out_inst !== 32'h13) begin errors++; $display("FAIL ill7_inst: got %h want 13", out_inst); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL ill7_err: got %b want 1", out_err); end
    drive(mk(6, 7'h13, 1, 2, 3, 0, 0, 32'h5));
    tick;
    checks++; if (out_inst !== 32'h13) begin errors++; $display("FAIL ill6_inst: got %h want 13", out_inst); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL ill6_err: got %b want 1", out_err); end
    checks++; if (out_addr !== 32'h4) begin errors++; $display("FAIL ill6_addr: got %h want 4", out_addr); end
    drive(addi);
    tick;
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL ill_after_err: got %b want 0", out_err); end
    checks++; if (out_addr !== 32'h8) begin errors++; $display("FAIL ill_after_addr: got %h want 8", out_addr); end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_range;
    req_t v[8];
    logic e[8];
    v[0] = mk(1, 7'h13, 1, 0, 0, 0, 0, 32'd2048);       e[0] = RC;
    v[1] = mk(1, 7'h13, 1, 0, 0, 0, 0, 32'hFFFF_F800);  e[1] = 1'b0;
    v[2] = mk(2, 7'h23, 0, 1, 2, 2, 0, 32'd2047);       e[2] = 1'b0;
    v[3] = mk(3, 7'h63, 0, 3, 4, 1, 0, 32'd6 + 32'd1);  e[3] = RC;
    v[4] = mk(3, 7'h63, 0, 3, 4, 1, 0, 32'hFFFF_F000);  e[4] = 1'b0;
    v[5] = mk(5, 7'h6F, 1, 0, 0, 0, 0, 32'h0010_0000);  e[5] = RC;
    v[6] = mk(4, 7'h37, 5, 0, 0, 0, 0, 32'h0000_0123);  e[6] = RC;
    v[7] = mk(2, 7'h23, 0, 1, 2, 2, 0, 32'hFFFF_E000);  e[7] = RC;
    do_reset;
    for (int i = 0; i < 8; i++) begin
      drive(v[i]);
      tick;
      checks++; if (out_err !== e[i]) begin errors++; $display("FAIL range_err[%0d]: got %b want %b", i, out_err, e[i]); end
      checks++; if (out_inst !== ref_enc(v[i])) begin errors++; $display("FAIL range_inst[%0d]: got %h want %h", i, out_inst, ref_enc(v[i])); end
    end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_addr_load;
    do_reset;
    drive(addi);
    tick;
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL al_first: got %h want 0", out_addr); end
    in_valid = 1'b0; addr_load = 1'b1; addr_base = 32'h100;
    tick;
    addr_load = 1'b0;
    drive(sw);
    tick;
    checks++; if (out_addr !== 32'h100) begin errors++; $display("FAIL al_base: got %h want 100", out_addr); end
    drive(lui);
    tick;
    checks++; if (out_addr !== 32'h104) begin errors++; $display("FAIL al_next: got %h want 104", out_addr); end
    out_ready = 1'b0; in_valid = 1'b0; addr_load = 1'b1; addr_base = 32'h200;
    tick;
    addr_load = 1'b0;
    checks++; if (out_addr !== 32'h104) begin errors++; $display("FAIL al_held_addr: got %h want 104", out_addr); end
    checks++; if (out_inst !== 32'h1234_52B7) begin errors++; $display("FAIL al_held_inst: got %h want 123452b7", out_inst); end
    out_ready = 1'b1;
    drive(jal);
    tick;
    checks++; if (out_addr !== 32'h200) begin errors++; $display("FAIL al_after_held: got %h want 200", out_addr); end
    checks++; if (out_inst !== 32'h6F) begin errors++; $display("FAIL al_after_inst: got %h want 6f", out_inst); end
    in_valid = 1'b0;
    tick;
    checks++; if (enc_count !== 16'd4) begin errors++; $display("FAIL al_count: got %0d want 4", enc_count); end
  endtask

  task automatic test_reset_midstream;
    do_reset;
    drive(addi);
    tick;
    drive(sw);
    tick;
    out_ready = 1'b0; in_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL mid_addr: got %h want 0", out_addr); end
    checks++; if (enc_count !== 16'h0) begin errors++; $display("FAIL mid_count: got %0d want 0", enc_count); end
    out_ready = 1'b1;
    drive(beq);
    tick;
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL mid_restart_addr: got %h want 0", out_addr); end
    checks++; if (out_inst !== 32'hFE00_0EE3) begin errors++; $display("FAIL mid_restart_inst: got %h want fe000ee3", out_inst); end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_random;
    logic [31:0] next_addr;
    logic [31:0] a;
    logic [15:0] delivered;
    logic        fire, acc;
    req_t        r;
    do_reset;
    exp_q.delete();
    next_addr = 32'h0;
    delivered = 16'h0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      r.fmt = 3'($urandom_range(0, 7));
      r.op = 7'($urandom_range(0, 127));
      r.rd = 5'($urandom_range(0, 31));
      r.rs1 = 5'($urandom_range(0, 31));
      r.rs2 = 5'($urandom_range(0, 31));
      r.f3 = 3'($urandom_range(0, 7));
      r.f7 = 7'($urandom_range(0, 127));
      case ($urandom_range(0, 3))
        0: r.imm = $urandom;
        1: r.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        2: r.imm = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFF_FFFE;
        default: r.imm = $urandom & 32'hFFFF_F000;
      endcase
      drive(r);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      addr_load = ($urandom_range(0, 15) == 0);
      addr_base = $urandom & 32'hFFFF_FFFC;
      #1;
      checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, out_valid, exp_q.size() != 0); end
      checks++; if (in_ready !== ((exp_q.size() == 0) || out_ready)) begin errors++; $display("FAIL rnd_ready@%0d: got %b", cyc, in_ready); end
      if (exp_q.size() != 0) begin
        checks++;
        if ({out_err, out_addr, out_inst} !== exp_q[0]) begin
          errors++;
          $display("FAIL rnd_word@%0d: got err=%b addr=%h inst=%h want err=%b addr=%h inst=%h", cyc,
                   out_err, out_addr, out_inst, exp_q[0][64], exp_q[0][63:32], exp_q[0][31:0]);
        end
      end
      fire = (exp_q.size() != 0) && out_ready;
      acc = in_valid && ((exp_q.size() == 0) || out_ready);
      if (fire) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (acc) begin
        a = addr_load ? addr_base : next_addr;
        exp_q.push_back({ref_err(r), a, ref_enc(r)});
        next_addr = a + 32'd4;
      end else if (addr_load) begin
        next_addr = addr_base;
      end
      tick;
    end
    in_valid = 1'b0; addr_load = 1'b0; out_ready = 1'b1;
    if (exp_q.size() != 0) delivered++;
    tick;
    checks++; if (enc_count !== delivered) begin errors++; $display("FAIL rnd_count: got %0d want %0d", enc_count, delivered); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain: got %b want 0", out_valid); end
  endtask

  initial begin
    addi = mk(1, 7'h13, 1, 0, 0, 0, 0, 32'd5);
    sw   = mk(2, 7'h23, 0, 1, 2, 2, 0, 32'd8);
    beq  = mk(3, 7'h63, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    lui  = mk(4, 7'h37, 5, 0, 0, 0, 0, 32'h1234_5000);
    jal  = mk(5, 7'h6F, 0, 0, 0, 0, 0, 32'h0);
    test_reset;
    test_directed;
    test_backpressure;
    test_illegal;
    test_range;
    test_addr_load;
    test_reset_midstream;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
